// File: rtl/carfield_regbus_pkg.sv
// Shared definitions for the Carfield regbus response demux: target windows,
// error read-data constants, address-rule type and FSM state encoding.
package carfield_regbus_pkg;

   localparam int unsigned NumTgt  = 4;
   localparam int unsigned TgtIdxW = 2;

   localparam logic [63:0] WinSize   = 64'h0000_0000_0000_1000;
   localparam logic [63:0] PcrsBase  = 64'h0000_0000_2001_0000;
   localparam logic [63:0] PllBase   = 64'h0000_0000_2002_0000;
   localparam logic [63:0] PadBase   = 64'h0000_0000_200A_0000;
   localparam logic [63:0] L2EccBase = 64'h0000_0000_200B_0000;

   localparam logic [31:0] ErrDecodeRdata  = 32'hBADC_AB1E;
   localparam logic [31:0] ErrTimeoutRdata = 32'hDEAD_BEEF;

   typedef struct packed {
      logic [TgtIdxW-1:0] idx;
      logic [63:0]        start_addr;
      logic [63:0]        end_addr;
   } addr_rule_t;

   localparam addr_rule_t [NumTgt-1:0] AddrMap = '{
      0: '{idx: 2'd0, start_addr: PcrsBase,  end_addr: PcrsBase  + WinSize},
      1: '{idx: 2'd1, start_addr: PllBase,   end_addr: PllBase   + WinSize},
      2: '{idx: 2'd2, start_addr: PadBase,   end_addr: PadBase   + WinSize},
      3: '{idx: 2'd3, start_addr: L2EccBase, end_addr: L2EccBase + WinSize}
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FWD,
      ST_WAIT,
      ST_RSP
   } state_e;

endpackage

// File: rtl/carfield_regbus_addr_decode.sv
// Combinational window decode: hit only for an enabled window and a word-aligned address.
module carfield_regbus_addr_decode
   import carfield_regbus_pkg::*;
(
   input  logic [63:0]         addr,
   input  logic [NumTgt-1:0]   enable,
   output logic                hit,
   output logic [TgtIdxW-1:0]  idx
);

   always_comb begin
      hit = 1'b0;
      idx = '0;
      if (addr[1:0] == 2'b00) begin
         for (int i = 0; i < NumTgt; i++) begin
            if (enable[i] && (addr >= AddrMap[i].start_addr) && (addr < AddrMap[i].end_addr)) begin
               hit = 1'b1;
               idx = AddrMap[i].idx;
            end
         end
      end
   end

endmodule

// File: rtl/carfield_regbus_demux_resp.sv
// Single-outstanding regbus demux to four config targets with decode-miss and
// timeout error responses and a saturating error counter.
module carfield_regbus_demux_resp
   import carfield_regbus_pkg::*;
#(
   parameter bit          PllCfgEnable      = 1'b1,
   parameter bit          PadframeCfgEnable = 1'b1,
   parameter bit          L2EccCfgEnable    = 1'b1,
   parameter int unsigned TimeoutCycles     = 255
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [63:0]          req_addr_i,
   input  logic                 req_write_i,
   input  logic [31:0]          req_wdata_i,
   input  logic [3:0]           req_wstrb_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [31:0]          rsp_rdata_o,
   output logic                 rsp_error_o,
   output logic [NumTgt-1:0]    tgt_req_valid_o,
   input  logic [NumTgt-1:0]    tgt_req_ready_i,
   output logic [11:0]          tgt_addr_o,
   output logic                 tgt_write_o,
   output logic [31:0]          tgt_wdata_o,
   output logic [3:0]           tgt_wstrb_o,
   input  logic [NumTgt-1:0]    tgt_rsp_valid_i,
   input  logic [NumTgt*32-1:0] tgt_rsp_rdata_i,
   input  logic [NumTgt-1:0]    tgt_rsp_error_i,
   output logic [15:0]          err_cnt_o
);

   localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);

   state_e              state_q, state_d;
   logic [11:0]         addr_q;
   logic                write_q;
   logic [31:0]         wdata_q;
   logic [3:0]          wstrb_q;
   logic [TgtIdxW-1:0]  idx_q;
   logic [15:0]         cnt_q;
   logic [31:0]         rdata_q;
   logic                err_q;
   logic [15:0]         err_cnt_q;

   logic                dec_hit;
   logic [TgtIdxW-1:0]  dec_idx;
   logic                accept, timeout, rsp_take, rsp_done;

   carfield_regbus_addr_decode i_decode (
      .addr   (req_addr_i),
      .enable ({L2EccCfgEnable, PadframeCfgEnable, PllCfgEnable, 1'b1}),
      .hit    (dec_hit),
      .idx    (dec_idx)
   );

   assign accept   = (state_q == ST_IDLE) && req_valid_i;
   assign timeout  = ((state_q == ST_FWD) || (state_q == ST_WAIT)) && (cnt_q == TimeoutLast);
   // Only the selected target's response is looked at; others are ignored.
   assign rsp_take = (state_q == ST_WAIT) && tgt_rsp_valid_i[idx_q];
   assign rsp_done = (state_q == ST_RSP) && rsp_ready_i;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (req_valid_i) state_d = dec_hit ? ST_FWD : ST_RSP;
         ST_FWD: begin
            if (timeout)                         state_d = ST_RSP;
            else if (tgt_req_ready_i[idx_q])     state_d = ST_WAIT;
         end
         ST_WAIT: if (rsp_take || timeout) state_d = ST_RSP;
         ST_RSP:  if (rsp_ready_i)        state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= req_addr_i[11:0];
            write_q <= req_write_i;
            wdata_q <= req_wdata_i;
            wstrb_q <= req_wstrb_i;
            idx_q   <= dec_idx;
            cnt_q   <= '0;
            rdata_q <= dec_hit ? 32'h0 : ErrDecodeRdata;
            err_q   <= ~dec_hit;
         end
         if ((state_q == ST_FWD) || (state_q == ST_WAIT)) cnt_q <= cnt_q + 16'd1;
         // A target response in the expiry cycle takes priority over the timeout.
         if (rsp_take) begin
            rdata_q <= tgt_rsp_rdata_i[{idx_q, 5'b0} +: 32];
            err_q   <= tgt_rsp_error_i[idx_q];
         end else if (timeout) begin
            rdata_q <= ErrTimeoutRdata;
            err_q   <= 1'b1;
         end
         if (rsp_done && err_q && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign req_ready_o     = (state_q == ST_IDLE);
   assign rsp_valid_o     = (state_q == ST_RSP);
   assign rsp_rdata_o     = (state_q == ST_RSP) ? rdata_q : 32'h0;
   assign rsp_error_o     = (state_q == ST_RSP) && err_q;
   assign tgt_req_valid_o = (state_q == ST_FWD) ? (NumTgt'(1) << idx_q) : '0;
   assign tgt_addr_o      = addr_q;
   assign tgt_write_o     = write_q;
   assign tgt_wdata_o     = wdata_q;
   assign tgt_wstrb_o     = wstrb_q;
   assign err_cnt_o       = err_cnt_q;

endmodule
